// File: rtl/frame_counter_pkg.sv
// Shared definitions for the APU frame sequencer: default step indices,
// $4017 bit positions and the debug step encoding.
package frame_counter_pkg;

  localparam int DEF_STEP1 = 7457;
  localparam int DEF_STEP2 = 14913;
  localparam int DEF_STEP3 = 22371;
  localparam int DEF_STEP4 = 29829;
  localparam int DEF_STEP5 = 37281;
  localparam int DEF_CW    = 16;

  localparam int MODE_BIT    = 7;
  localparam int INHIBIT_BIT = 6;

  typedef enum logic [2:0] {
    STEP_NONE = 3'd0,
    STEP_Q1   = 3'd1,
    STEP_H2   = 3'd2,
    STEP_Q3   = 3'd3,
    STEP_H4   = 3'd4,
    STEP_H5   = 3'd5
  } frame_step_e;

endpackage

// File: rtl/frame_counter_toggle_sync.sv
// Brings a toggle-per-event signal from another clock domain into clk and
// turns each toggle into a single-cycle pulse.
module frame_counter_toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic toggle,
  output logic pulse
);

  logic [1:0] sync;

  // Two-flop synchroniser followed by a registered edge compare of the two stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], toggle};
      pulse <= sync[1] ^ sync[0];
    end
  end

endmodule

// File: rtl/frame_counter.sv
// APU frame sequencer: divides the CPU-rate clock into quarter-frame and
// half-frame strobes, supports 4-step and 5-step modes and raises the frame IRQ.
module frame_counter
  import frame_counter_pkg::*;
#(
  parameter int STEP1 = DEF_STEP1,
  parameter int STEP2 = DEF_STEP2,
  parameter int STEP3 = DEF_STEP3,
  parameter int STEP4 = DEF_STEP4,
  parameter int STEP5 = DEF_STEP5,
  parameter int CW    = DEF_CW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] reg_4017,
  input  logic       reg_change,
  input  logic       irq_clear,
  output logic       enable_240hz,
  output logic       enable_120hz,
  output logic       frame_irq,
  output logic [2:0] frame_step
);

  localparam logic [CW-1:0] C_STEP1 = CW'(STEP1);
  localparam logic [CW-1:0] C_STEP2 = CW'(STEP2);
  localparam logic [CW-1:0] C_STEP3 = CW'(STEP3);
  localparam logic [CW-1:0] C_STEP4 = CW'(STEP4);
  localparam logic [CW-1:0] C_STEP5 = CW'(STEP5);

  logic          write_pulse;
  logic          write_evt;
  logic          mode;
  logic          inhibit;
  logic [CW-1:0] count;
  frame_step_e   step_q;
  logic          unused_bits;

  // Only the mode and inhibit bits of $4017 matter to the sequencer
  assign unused_bits = ^reg_4017[5:0];
  assign frame_step  = step_q;

  frame_counter_toggle_sync u_write_sync (
    .clk    (clk),
    .rst    (rst),
    .toggle (reg_change),
    .pulse  (write_pulse)
  );

  // Extra register stage so the write lands a fixed three clocks after the toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_evt <= 1'b0;
    end else begin
      write_evt <= write_pulse;
    end
  end

  // Cycle counter, step decode, registered strobes and the frame IRQ flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= '0;
      mode         <= 1'b0;
      inhibit      <= 1'b0;
      enable_240hz <= 1'b0;
      enable_120hz <= 1'b0;
      frame_irq    <= 1'b0;
      step_q       <= STEP_NONE;
    end else begin
      enable_240hz <= 1'b0;
      enable_120hz <= 1'b0;
      if (write_evt) begin
        mode    <= reg_4017[MODE_BIT];
        inhibit <= reg_4017[INHIBIT_BIT];
        count   <= '0;
        step_q  <= STEP_NONE;
        if (reg_4017[MODE_BIT]) begin
          enable_240hz <= 1'b1;
          enable_120hz <= 1'b1;
        end
        if (reg_4017[INHIBIT_BIT] || irq_clear) begin
          frame_irq <= 1'b0;
        end
      end else begin
        count <= count + CW'(1);
        if (irq_clear) begin
          frame_irq <= 1'b0;
        end
        if (count == C_STEP1) begin
          enable_240hz <= 1'b1;
          step_q       <= STEP_Q1;
        end else if (count == C_STEP2) begin
          enable_240hz <= 1'b1;
          enable_120hz <= 1'b1;
          step_q       <= STEP_H2;
        end else if (count == C_STEP3) begin
          enable_240hz <= 1'b1;
          step_q       <= STEP_Q3;
        end else if (count == C_STEP4) begin
          step_q <= STEP_H4;
          if (!mode) begin
            enable_240hz <= 1'b1;
            enable_120hz <= 1'b1;
            count        <= '0;
            if (!inhibit) begin
              frame_irq <= 1'b1;
            end
          end
        end else if (count == C_STEP5 && mode) begin
          enable_240hz <= 1'b1;
          enable_120hz <= 1'b1;
          step_q       <= STEP_H5;
          count        <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_counter.sv
// Self-checking bench for frame_counter: a short-step instance driven by
// directed and random writes/IRQ acknowledges, plus a default-step instance
// left free-running for one full 4-step frame.
module tb_frame_counter;

  localparam int S1 = 10;
  localparam int S2 = 20;
  localparam int S3 = 30;
  localparam int S4 = 40;
  localparam int S5 = 50;
  localparam int STEPS [5] = '{S1, S2, S3, S4, S5};
  localparam int DEF_PERIOD = 29830;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_def;
  logic [7:0] reg_4017;
  logic       reg_change;
  logic       irq_clear;
  logic       enable_240hz;
  logic       enable_120hz;
  logic       frame_irq;
  logic [2:0] frame_step;

  logic [7:0] def_reg;
  logic       def_change;
  logic       def_clear;
  logic       def_240;
  logic       def_120;
  logic       def_irq;
  logic [2:0] def_step;

  int         checks;
  int         errors;

  int         k;
  int         pend;
  int         cyc;
  logic [7:0] pend_val;
  logic       m_mode;
  logic       m_inh;
  logic       m_irq;
  int         m_step;
  logic       x240;
  logic       x120;

  always #5 clk = ~clk;

  frame_counter #(
    .STEP1 (S1),
    .STEP2 (S2),
    .STEP3 (S3),
    .STEP4 (S4),
    .STEP5 (S5),
    .CW    (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .reg_4017     (reg_4017),
    .reg_change   (reg_change),
    .irq_clear    (irq_clear),
    .enable_240hz (enable_240hz),
    .enable_120hz (enable_120hz),
    .frame_irq    (frame_irq),
    .frame_step   (frame_step)
  );

  frame_counter dut_def (
    .clk          (clk),
    .rst          (rst_def),
    .reg_4017     (def_reg),
    .reg_change   (def_change),
    .irq_clear    (def_clear),
    .enable_240hz (def_240),
    .enable_120hz (def_120),
    .frame_irq    (def_irq),
    .frame_step   (def_step)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      if (errors <= 25) $error("[TB] FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_step(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      if (errors <= 25) $error("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference behaviour of the short-step instance for one rising edge.
  // k counts edges since the last restart, so the counter seen by this edge is k mod period.
  task automatic model_edge(input logic clr);
    int   pos;
    int   period;
    logic restart;
    x240    = 1'b0;
    x120    = 1'b0;
    restart = 1'b0;
    if (pend > 0) begin
      pend--;
      restart = (pend == 0);
    end
    if (restart) begin
      m_mode = pend_val[7];
      m_inh  = pend_val[6];
      k      = 0;
      m_step = 0;
      x240   = m_mode;
      x120   = m_mode;
      if (m_inh || clr) m_irq = 1'b0;
    end else begin
      period = m_mode ? S5 + 1 : S4 + 1;
      pos    = k % period;
      k++;
      if (clr) m_irq = 1'b0;
      for (int i = 0; i < 5; i++) begin
        if (pos == STEPS[i]) begin
          m_step = i + 1;
          if (!(i == 3 && m_mode)) begin
            x240 = 1'b1;
            x120 = (i == 1) || (i >= 3);
          end
          if (i == 3 && !m_mode && !m_inh) m_irq = 1'b1;
        end
      end
    end
  endtask

  // Free-running default instance: steps at 7457/14913/22371/29829 of a 29830-clock frame
  task automatic check_default();
    int         p;
    logic       q;
    logic       h;
    logic [2:0] s;
    p = (cyc - 1) % DEF_PERIOD;
    q = (cyc > 0) && (p == 7457 || p == 14913 || p == 22371 || p == 29829);
    h = (cyc > 0) && (p == 14913 || p == 29829);
    if (cyc == 0)          s = 3'd0;
    else if (p >= 29829)   s = 3'd4;
    else if (p >= 22371)   s = 3'd3;
    else if (p >= 14913)   s = 3'd2;
    else if (p >= 7457)    s = 3'd1;
    else if (cyc > DEF_PERIOD) s = 3'd4;
    else                   s = 3'd0;
    check_bit("def_240hz", def_240, q);
    check_bit("def_120hz", def_120, h);
    check_bit("def_irq", def_irq, cyc >= DEF_PERIOD);
    check_step("def_step", def_step, s);
  endtask

  task automatic checkOutput();
    check_bit("enable_240hz", enable_240hz, x240);
    check_bit("enable_120hz", enable_120hz, x120);
    check_bit("frame_irq", frame_irq, m_irq);
    check_step("frame_step", frame_step, 3'(m_step));
    check_default();
  endtask

  task automatic applyStimulus(input logic clr, input logic wr, input logic [7:0] val);
    @(negedge clk);
    irq_clear = clr;
    if (wr) begin
      reg_4017   = val;
      reg_change = ~reg_change;
      pend       = 4;
      pend_val   = val;
    end
    @(posedge clk);
    model_edge(clr);
    cyc++;
    #1;
    checkOutput();
  endtask

  task automatic run(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic model_reset();
    k      = 0;
    pend   = 0;
    m_mode = 1'b0;
    m_inh  = 1'b0;
    m_irq  = 1'b0;
    m_step = 0;
    x240   = 1'b0;
    x120   = 1'b0;
  endtask

  // Mid-frame reset of the short-step instance for one clock
  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    irq_clear  = 1'b0;
    reg_change = 1'b0;
    #1;
    check_bit("rst_async_240", enable_240hz, 1'b0);
    check_bit("rst_async_120", enable_120hz, 1'b0);
    check_bit("rst_async_irq", frame_irq, 1'b0);
    check_step("rst_async_step", frame_step, 3'd0);
    @(posedge clk);
    cyc++;
    #1;
    check_default();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        clr;
    logic        wr;
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    pend_val   = 8'h00;
    rst        = 1'b1;
    rst_def    = 1'b1;
    reg_4017   = 8'h00;
    reg_change = 1'b0;
    irq_clear  = 1'b0;
    def_reg    = 8'h00;
    def_change = 1'b0;
    def_clear  = 1'b0;
    model_reset();

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset_240", enable_240hz, 1'b0);
    check_bit("reset_120", enable_120hz, 1'b0);
    check_bit("reset_irq", frame_irq, 1'b0);
    check_step("reset_step", frame_step, 3'd0);
    check_default();
    rst     = 1'b0;
    rst_def = 1'b0;

    // 4-step frame from reset, IRQ at step 4, second frame start
    run(90);

    // IRQ acknowledge, then acknowledge coinciding with step 4
    applyStimulus(1'b1, 1'b0, 8'h00);
    while ((k % (S4 + 1)) != S4) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    run(5);

    // Switch to 5-step mode
    applyStimulus(1'b0, 1'b1, 8'h80);
    run(120);

    // Back to 4-step, let the IRQ set, then inhibit it and re-enable
    applyStimulus(1'b0, 1'b1, 8'h00);
    run(45);
    applyStimulus(1'b0, 1'b1, 8'h40);
    run(100);
    applyStimulus(1'b0, 1'b1, 8'h00);
    run(45);

    // Write landing on the step-2 count
    while (!(pend == 0 && (k % (S4 + 1)) == S2 - 3)) applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    run(30);

    // Reset at count 25, then again right after a strobe
    while ((k % (S4 + 1)) != 25) applyStimulus(1'b0, 1'b0, 8'h00);
    do_reset();
    run(60);
    applyStimulus(1'b0, 1'b0, 8'h00);
    while (!x240) applyStimulus(1'b0, 1'b0, 8'h00);
    do_reset();
    run(45);

    // Random writes and acknowledges until the default instance has completed a frame
    while (cyc < DEF_PERIOD + 300) begin
      r   = $urandom;
      clr = ($urandom_range(0, 15) == 0);
      wr  = (pend == 0) && ($urandom_range(0, 79) == 0);
      applyStimulus(clr, wr, r[7:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
